// File: rtl/seven_seg_pkg.sv
// Shared types and the hex-to-segment table for the multiplexed
// seven-segment scanner.
package seven_seg_pkg;

   typedef logic [6:0] seg_t;

   localparam seg_t SEG_BLANK = 7'b0000000;

   // Active-high a..g patterns, bit 6 = a, bit 0 = g, indexed by nibble.
   localparam seg_t HEX_SEG [16] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
      7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
      7'b1111111, 7'b1110011, 7'b1110111, 7'b0011111,
      7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
   };

   function automatic int unsigned cnt_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational nibble to active-high segment decoder.
// Uses the package table so there is a single source of the glyphs.
module hex_to_seg
   import seven_seg_pkg::*;
(
   input  logic [3:0] i_nib,
   output seg_t       o_seg
);

   always_comb begin
      o_seg = HEX_SEG[i_nib];
   end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed seven-segment scanner with frame-synchronous
// double-buffered loads, leading-zero suppression and per-digit blanking.
module seven_seg_scanner
   import seven_seg_pkg::*;
#(
   parameter int NUM_DIGITS     = 4,
   parameter int REFRESH_DIV    = 50000,
   parameter int SEG_ACTIVE_LOW = 0,
   parameter int DIG_ACTIVE_LOW = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load_i,
   input  logic [4*NUM_DIGITS-1:0] value_i,
   input  logic [NUM_DIGITS-1:0]   dp_i,
   input  logic [NUM_DIGITS-1:0]   blank_i,
   input  logic                    lzs_en_i,
   output logic [6:0]              segments_o,
   output logic                    dp_o,
   output logic [NUM_DIGITS-1:0]   digit_en_o,
   output logic                    frame_o,
   output logic                    pending_o
);

   localparam int PW = cnt_width(REFRESH_DIV);
   localparam int IW = cnt_width(NUM_DIGITS);
   localparam int VW = 4 * NUM_DIGITS;

   localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
   localparam logic [PW-1:0] PRE_PEN  = PW'(REFRESH_DIV - 2);
   localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

   localparam seg_t SEG_POL = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic DP_POL  = (SEG_ACTIVE_LOW != 0);
   localparam logic [NUM_DIGITS-1:0] DIG_POL =
      (DIG_ACTIVE_LOW != 0) ? '1 : '0;

   logic [PW-1:0]         r_pre;
   logic [IW-1:0]         r_idx;
   logic [VW-1:0]         r_disp;
   logic [NUM_DIGITS-1:0] r_dp;
   logic [VW-1:0]         r_shadow;
   logic [NUM_DIGITS-1:0] r_shdp;
   logic                  r_pend;
   logic                  r_frame;
   seg_t                  r_seg;
   logic                  r_dpo;
   logic [NUM_DIGITS-1:0] r_en;

   logic                  w_tick;
   logic                  w_wrap;
   logic                  w_frame_nxt;
   logic [3:0]            w_nib;
   logic                  w_dpsel;
   logic [NUM_DIGITS-1:0] w_sel;
   logic [NUM_DIGITS-1:0] w_lead;
   logic                  w_supp;
   logic                  w_blank;
   logic                  w_dark;
   seg_t                  w_seg;

   assign w_tick      = (r_pre == PRE_LAST);
   assign w_wrap      = w_tick && (r_idx == IDX_LAST);
   // frame_o is registered, so flag the wrap one cycle ahead.
   assign w_frame_nxt = (r_pre == PRE_PEN) && (r_idx == IDX_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pre   <= '0;
         r_idx   <= '0;
         r_frame <= 1'b0;
      end else begin
         r_frame <= w_frame_nxt;
         if (w_tick) begin
            r_pre <= '0;
            r_idx <= w_wrap ? '0 : r_idx + IW'(1);
         end else begin
            r_pre <= r_pre + PW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_disp   <= '0;
         r_dp     <= '0;
         r_shadow <= '0;
         r_shdp   <= '0;
         r_pend   <= 1'b0;
      end else if (w_wrap) begin
         r_pend <= 1'b0;
         if (load_i) begin
            r_disp <= value_i;
            r_dp   <= dp_i;
         end else if (r_pend) begin
            r_disp <= r_shadow;
            r_dp   <= r_shdp;
         end
      end else if (load_i) begin
         r_shadow <= value_i;
         r_shdp   <= dp_i;
         r_pend   <= 1'b1;
      end
   end

   always_comb begin
      w_nib   = 4'h0;
      w_dpsel = 1'b0;
      w_sel   = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (r_idx == IW'(i)) begin
            w_nib    = r_disp[4*i +: 4];
            w_dpsel  = r_dp[i];
            w_sel[i] = 1'b1;
         end
      end
   end

   // w_lead[i]: every nibble from the top digit down to i is zero.
   always_comb begin
      logic w_run;
      w_run  = 1'b1;
      w_lead = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         w_run     = w_run & (r_disp[4*i +: 4] == 4'h0);
         w_lead[i] = w_run;
      end
   end

   assign w_supp  = lzs_en_i && (r_idx != '0) && |(w_lead & w_sel);
   assign w_blank = |(blank_i & w_sel);
   assign w_dark  = w_supp || w_blank;

   hex_to_seg u_dec (
      .i_nib (w_nib),
      .o_seg (w_seg)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_seg <= SEG_POL;
         r_dpo <= DP_POL;
         r_en  <= DIG_POL;
      end else begin
         r_seg <= (w_dark ? SEG_BLANK : w_seg) ^ SEG_POL;
         r_dpo <= (w_dark ? 1'b0 : w_dpsel) ^ DP_POL;
         r_en  <= (w_dark ? '0 : w_sel) ^ DIG_POL;
      end
   end

   assign segments_o = r_seg;
   assign dp_o       = r_dpo;
   assign digit_en_o = r_en;
   assign frame_o    = r_frame;
   assign pending_o  = r_pend;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Randomized and directed check of seven_seg_scanner against a
// cycle-count based reference model.
module tb_seven_seg_scanner;

   localparam int N   = 4;
   localparam int DIV = 4;
   localparam int FR  = N * DIV;

   logic        clk      = 1'b0;
   logic        rst      = 1'b1;
   logic        load_i   = 1'b0;
   logic [15:0] value_i  = '0;
   logic [3:0]  dp_i     = '0;
   logic [3:0]  blank_i  = '0;
   logic        lzs_en_i = 1'b0;
   logic [6:0]  segments_o;
   logic        dp_o;
   logic [3:0]  digit_en_o;
   logic        frame_o;
   logic        pending_o;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   logic [15:0] m_disp, m_shadow;
   logic [3:0]  m_dp, m_shdp;
   logic        m_pend;
   logic [6:0]  glyph [16];

   seven_seg_scanner #(
      .NUM_DIGITS     (N),
      .REFRESH_DIV    (DIV),
      .SEG_ACTIVE_LOW (0),
      .DIG_ACTIVE_LOW (1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .load_i     (load_i),
      .value_i    (value_i),
      .dp_i       (dp_i),
      .blank_i    (blank_i),
      .lzs_en_i   (lzs_en_i),
      .segments_o (segments_o),
      .dp_o       (dp_o),
      .digit_en_o (digit_en_o),
      .frame_o    (frame_o),
      .pending_o  (pending_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: predict the pins after the edge, advance the model,
   // then compare just after the edge.
   task automatic step();
      logic [6:0] e_seg;
      logic       e_dp, e_fr, e_pd;
      logic [3:0] e_en;
      int         s;
      bit         dark;
      if (rst) begin
         e_seg = 7'h00; e_dp = 1'b0; e_en = 4'hF;
         e_fr = 1'b0; e_pd = 1'b0;
         m_disp = '0; m_dp = '0; m_shadow = '0; m_shdp = '0;
         m_pend = 1'b0;
         cyc = 0;
      end else begin
         s = (cyc / DIV) % N;
         dark = blank_i[s] ||
                (lzs_en_i && s > 0 && (m_disp >> (4 * s)) == 16'h0);
         e_seg = dark ? 7'h00 : glyph[m_disp[4*s +: 4]];
         e_dp  = dark ? 1'b0 : m_dp[s];
         e_en  = dark ? 4'hF : ~(4'b0001 << s);
         e_fr  = ((cyc + 1) % FR) == FR - 1;
         if (cyc % FR == FR - 1) begin
            if (load_i) begin
               m_disp = value_i; m_dp = dp_i;
            end else if (m_pend) begin
               m_disp = m_shadow; m_dp = m_shdp;
            end
            m_pend = 1'b0;
         end else if (load_i) begin
            m_shadow = value_i; m_shdp = dp_i; m_pend = 1'b1;
         end
         e_pd = m_pend;
         cyc++;
      end
      @(posedge clk);
      #1;
      chk("segments", 32'(segments_o), 32'(e_seg));
      chk("dp",       32'(dp_o),       32'(e_dp));
      chk("digit_en", 32'(digit_en_o), 32'(e_en));
      chk("frame",    32'(frame_o),    32'(e_fr));
      chk("pending",  32'(pending_o),  32'(e_pd));
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic to_phase(input int ph);
      for (int k = 0; k < 2 * FR && (cyc % FR) != ph; k++) step();
      chk("phase_wait", 32'(cyc % FR), 32'(ph));
   endtask

   task automatic load(input logic [15:0] v, input logic [3:0] d);
      load_i = 1'b1; value_i = v; dp_i = d;
      step();
      load_i = 1'b0; value_i = 16'($urandom); dp_i = 4'($urandom);
   endtask

   initial begin
      glyph = '{
         7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
         7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
         7'b1111111, 7'b1110011, 7'b1110111, 7'b0011111,
         7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
      };
      rst = 1'b1;
      run(3);
      rst = 1'b0;
      chk("reset_seg", 32'(segments_o), 32'h00);
      chk("reset_en",  32'(digit_en_o), 32'hF);
      step();
      chk("first_seg", 32'(segments_o), 32'h7E);
      chk("first_en",  32'(digit_en_o), 32'hE);
      run(40);

      to_phase(5);
      load(16'h12AF, 4'b0101);
      run(30);

      lzs_en_i = 1'b1;
      to_phase(2);
      load(16'h0050, 4'b0000);
      run(36);
      load(16'h0000, 4'b0001);
      run(36);
      lzs_en_i = 1'b0;

      for (int k = 0; k < 2 * FR && frame_o !== 1'b1; k++) step();
      chk("wait_frame", 32'(frame_o), 32'h1);
      load(16'h8888, 4'b1111);
      run(36);

      to_phase(3);
      load(16'hABCD, 4'b0011);
      run(4);
      load(16'h3456, 4'b1000);
      run(30);

      for (int k = 0; k < 400; k++) begin
         load_i   = ($urandom_range(7) == 0);
         value_i  = 16'($urandom);
         dp_i     = 4'($urandom);
         blank_i  = ($urandom_range(3) == 0) ? 4'($urandom) : 4'h0;
         if ($urandom_range(15) == 0) lzs_en_i = ~lzs_en_i;
         if ($urandom_range(5) == 0) value_i[15:8] = 8'h00;
         step();
      end
      load_i = 1'b0; blank_i = 4'h0; lzs_en_i = 1'b0;
      run(20);

      for (int k = 0; k < 2 * FR && digit_en_o !== 4'b1011; k++) step();
      chk("wait_digit2", 32'(digit_en_o), 32'hB);
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      chk("post_rst_en",  32'(digit_en_o), 32'hE);
      chk("post_rst_seg", 32'(segments_o), 32'h7E);
      run(40);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
